// File: rtl/core_decode_queue.sv
// RV32IM decode stage: decodes {pc, instr} at enqueue and buffers bundles in a DEPTH-entry ring.
// Optional illegal-encoding detection is enabled by defining CORE_DECODE_QUEUE_ILLEGAL_EN.
package core_pkg;
    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_type_e;
    typedef enum logic [1:0] {SRC_RR = 2'd0, SRC_RI = 2'd1, SRC_PI = 2'd2, SRC_ZI = 2'd3} exec_src_e;
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
        ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
        ALU_SUB = 4'b1000, ALU_SRA = 4'b1101
    } alu_op_e;
    typedef enum logic [1:0] {MUL_MUL = 2'd0, MUL_MULH = 2'd1, MUL_MULHSU = 2'd2, MUL_MULHU = 2'd3} mul_op_e;
    typedef enum logic [1:0] {DIV_DIV = 2'd0, DIV_DIVU = 2'd1, DIV_REM = 2'd2, DIV_REMU = 2'd3} div_op_e;
    typedef enum logic [1:0] {EXEC_ALU = 2'd0, EXEC_MUL = 2'd1, EXEC_DIV = 2'd2} exec_engine_e;
    typedef enum logic [1:0] {WB_NONE = 2'd0, WB_EXEC = 2'd1, WB_MEM = 2'd2, WB_FETCH = 2'd3} wb_src_e;
    typedef enum logic [1:0] {PC_NORMAL = 2'd0, PC_JUMP = 2'd1, PC_BRANCH = 2'd2} pc_src_e;
    typedef enum logic {BRANCH_Z = 1'b0, BRANCH_NZ = 1'b1} br_type_e;
    typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_dir_e;
    typedef enum logic [2:0] {MEM_B = 3'b000, MEM_H = 3'b001, MEM_W = 3'b010, MEM_BU = 3'b100, MEM_HU = 3'b101} mem_size_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
endpackage

module core_decode_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_imm,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output imm_type_e                out_imm_type,
    output exec_src_e                out_exec_src,
    output alu_op_e                  out_alu_op,
    output mul_op_e                  out_mul_op,
    output div_op_e                  out_div_op,
    output exec_engine_e             out_exec_engine,
    output wb_src_e                  out_wb_src,
    output pc_src_e                  out_pc_src,
    output br_type_e                 out_br_type,
    output logic                     out_mem_op,
    output mem_dir_e                 out_mem_dir,
    output mem_size_e                out_mem_size,
    output logic                     out_ecall,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        imm_type_e       imm_type;
        exec_src_e       exec_src;
        alu_op_e         alu_op;
        mul_op_e         mul_op;
        div_op_e         div_op;
        exec_engine_e    exec_engine;
        wb_src_e         wb_src;
        pc_src_e         pc_src;
        br_type_e        br_type;
        logic            mem_op;
        mem_dir_e        mem_dir;
        mem_size_e       mem_size;
        logic            ecall;
        logic            illegal;
    } entry_t;

    entry_t          mem_r [DEPTH];
    entry_t          entry_s;
    entry_t          head_s;
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;
    logic            illegal_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;

    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];

`ifdef CORE_DECODE_QUEUE_ILLEGAL_EN
    logic [6:0] funct7_s;
    assign funct7_s = in_instr[31:25];

    // Flag encodings outside the supported RV32IM subset.
    always_comb begin
        illegal_s = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_OP: begin
                    if (funct7_s == 7'b0000000) begin
                        illegal_s = 1'b0;
                    end else if (funct7_s == 7'b0100000) begin
                        illegal_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                    end else if (funct7_s == 7'b0000001) begin
                        illegal_s = (M_EXT == 0);
                    end else begin
                        illegal_s = 1'b1;
                    end
                end
                OPC_OPIMM: begin
                    if (funct3_s == 3'b001) begin
                        illegal_s = (funct7_s != 7'b0000000);
                    end else if (funct3_s == 3'b101) begin
                        illegal_s = !((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000));
                    end else begin
                        illegal_s = 1'b0;
                    end
                end
                OPC_BRANCH: illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
                OPC_LOAD:   illegal_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
                OPC_STORE:  illegal_s = (funct3_s >= 3'b011);
                OPC_JALR:   illegal_s = (funct3_s != 3'b000);
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_MISC_MEM: illegal_s = 1'b0;
                default:    illegal_s = 1'b1;
            endcase
        end
    end
`else
    assign illegal_s = 1'b0;
`endif

    // Decode the incoming instruction into a queue entry.
    always_comb begin
        entry_s             = '0;
        entry_s.pc          = in_pc;
        entry_s.rd          = in_instr[11:7];
        entry_s.rs1         = in_instr[19:15];
        entry_s.rs2         = in_instr[24:20];
        entry_s.imm_type    = IMM_I;
        entry_s.exec_src    = SRC_RR;
        entry_s.alu_op      = ALU_ADD;
        entry_s.mul_op      = mul_op_e'(funct3_s[1:0]);
        entry_s.div_op      = div_op_e'(funct3_s[1:0]);
        entry_s.exec_engine = EXEC_ALU;
        entry_s.wb_src      = WB_NONE;
        entry_s.pc_src      = PC_NORMAL;
        entry_s.br_type     = BRANCH_Z;
        entry_s.mem_op      = 1'b0;
        entry_s.mem_dir     = MEM_READ;
        entry_s.mem_size    = mem_size_e'(funct3_s);
        entry_s.ecall       = (opcode_s == OPC_SYSTEM) && (in_instr[31:7] == 25'd0);
        entry_s.illegal     = illegal_s;
        // An illegal encoding keeps the default bundle built above.
        if (illegal_s) begin
            entry_s.ecall = 1'b0;
        end else begin
            case (opcode_s)
                OPC_OP: begin
                    entry_s.wb_src = WB_EXEC;
                    entry_s.alu_op = alu_op_e'({in_instr[30], funct3_s});
                    if (in_instr[25] && (M_EXT == 1)) begin
                        entry_s.exec_engine = funct3_s[2] ? EXEC_DIV : EXEC_MUL;
                    end else begin
                        entry_s.exec_engine = EXEC_ALU;
                    end
                end
                OPC_OPIMM: begin
                    entry_s.exec_src = SRC_RI;
                    entry_s.wb_src   = WB_EXEC;
                    if (funct3_s[1:0] == 2'b01) begin
                        entry_s.alu_op = alu_op_e'({in_instr[30], funct3_s});
                    end else begin
                        entry_s.alu_op = alu_op_e'({1'b0, funct3_s});
                    end
                end
                OPC_LUI: begin
                    entry_s.imm_type = IMM_U;
                    entry_s.exec_src = SRC_ZI;
                    entry_s.wb_src   = WB_EXEC;
                end
                OPC_AUIPC: begin
                    entry_s.imm_type = IMM_U;
                    entry_s.exec_src = SRC_PI;
                    entry_s.wb_src   = WB_EXEC;
                end
                OPC_JAL: begin
                    entry_s.imm_type = IMM_J;
                    entry_s.exec_src = SRC_PI;
                    entry_s.wb_src   = WB_FETCH;
                    entry_s.pc_src   = PC_JUMP;
                end
                OPC_JALR: begin
                    entry_s.exec_src = SRC_RI;
                    entry_s.wb_src   = WB_FETCH;
                    entry_s.pc_src   = PC_JUMP;
                end
                OPC_BRANCH: begin
                    entry_s.imm_type = IMM_B;
                    entry_s.pc_src   = PC_BRANCH;
                    case (funct3_s)
                        3'b000, 3'b001: entry_s.alu_op = ALU_SUB;
                        3'b100, 3'b101: entry_s.alu_op = ALU_SLT;
                        3'b110, 3'b111: entry_s.alu_op = ALU_SLTU;
                        default:        entry_s.alu_op = ALU_ADD;
                    endcase
                    case (funct3_s)
                        3'b001, 3'b100, 3'b110: entry_s.br_type = BRANCH_NZ;
                        default:                entry_s.br_type = BRANCH_Z;
                    endcase
                end
                OPC_LOAD: begin
                    entry_s.exec_src = SRC_RI;
                    entry_s.wb_src   = WB_MEM;
                    entry_s.mem_op   = 1'b1;
                end
                OPC_STORE: begin
                    entry_s.imm_type = IMM_S;
                    entry_s.exec_src = SRC_RI;
                    entry_s.mem_op   = 1'b1;
                    entry_s.mem_dir  = MEM_WRITE;
                end
                default: entry_s.imm_type = IMM_I;
            endcase
        end
        case (entry_s.imm_type)
            IMM_S:   entry_s.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            IMM_B:   entry_s.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
            IMM_U:   entry_s.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            IMM_J:   entry_s.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
            default: entry_s.imm = XLEN'($signed(in_instr[31:20]));
        endcase
    end

    assign in_ready  = (count_r != CW'(DEPTH));
    assign out_valid = (count_r != CW'(0));
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Entry storage; written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !flush) begin
            mem_r[wptr_r] <= entry_s;
        end else begin
            mem_r[wptr_r] <= mem_r[wptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s          = mem_r[rptr_r];
    assign out_pc          = head_s.pc;
    assign out_imm         = head_s.imm;
    assign out_rd          = head_s.rd;
    assign out_rs1         = head_s.rs1;
    assign out_rs2         = head_s.rs2;
    assign out_imm_type    = head_s.imm_type;
    assign out_exec_src    = head_s.exec_src;
    assign out_alu_op      = head_s.alu_op;
    assign out_mul_op      = head_s.mul_op;
    assign out_div_op      = head_s.div_op;
    assign out_exec_engine = head_s.exec_engine;
    assign out_wb_src      = head_s.wb_src;
    assign out_pc_src      = head_s.pc_src;
    assign out_br_type     = head_s.br_type;
    assign out_mem_op      = head_s.mem_op;
    assign out_mem_dir     = head_s.mem_dir;
    assign out_mem_size    = head_s.mem_size;
    assign out_ecall       = head_s.ecall;
    assign out_illegal     = head_s.illegal;
    assign count           = count_r;

endmodule

// File: tb/tb_core_decode_queue.sv
// Bench for core_decode_queue: hand-decoded vector table, scoreboard on the output handshake,
// plus full/wrap, flush and asynchronous-reset sequences.
module tb_core_decode_queue;
    import core_pkg::*;

    localparam int NV = 13;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [31:0]  in_instr;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_imm;
    logic [4:0]   out_rd;
    logic [4:0]   out_rs1;
    logic [4:0]   out_rs2;
    imm_type_e    out_imm_type;
    exec_src_e    out_exec_src;
    alu_op_e      out_alu_op;
    mul_op_e      out_mul_op;
    div_op_e      out_div_op;
    exec_engine_e out_exec_engine;
    wb_src_e      out_wb_src;
    pc_src_e      out_pc_src;
    br_type_e     out_br_type;
    logic         out_mem_op;
    mem_dir_e     out_mem_dir;
    mem_size_e    out_mem_size;
    logic         out_ecall;
    logic         out_illegal;
    logic [1:0]   count;

    core_decode_queue #(.DEPTH(2), .XLEN(32), .M_EXT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm_type(out_imm_type), .out_exec_src(out_exec_src), .out_alu_op(out_alu_op),
        .out_mul_op(out_mul_op), .out_div_op(out_div_op), .out_exec_engine(out_exec_engine),
        .out_wb_src(out_wb_src), .out_pc_src(out_pc_src), .out_br_type(out_br_type),
        .out_mem_op(out_mem_op), .out_mem_dir(out_mem_dir), .out_mem_size(out_mem_size),
        .out_ecall(out_ecall), .out_illegal(out_illegal), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  imm;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        imm_type_e    imm_type;
        exec_src_e    src;
        alu_op_e      alu;
        mul_op_e      mul;
        div_op_e      div;
        exec_engine_e eng;
        wb_src_e      wb;
        pc_src_e      pcs;
        br_type_e     br;
        logic         mem_op;
        mem_dir_e     dir;
        mem_size_e    size;
        logic         ecall;
        logic         illegal;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

`ifdef CORE_DECODE_QUEUE_ILLEGAL_EN
    localparam logic ILL_ZERO = 1'b1;
`else
    localparam logic ILL_ZERO = 1'b0;
`endif

    vec_t vecs [NV];
    dec_t sb [$];
    dec_t mon_exp;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_dec(input string name, input dec_t act, input dec_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic dec_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input imm_type_e it, input exec_src_e src,
                                input alu_op_e alu, input logic [1:0] md, input exec_engine_e eng,
                                input wb_src_e wb, input pc_src_e pcs, input br_type_e br,
                                input logic mem_op, input mem_dir_e dir, input mem_size_e size,
                                input logic ecall, input logic illegal);
        dec_t d;
        d.pc = 32'd0; d.imm = imm; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
        d.imm_type = it; d.src = src; d.alu = alu;
        d.mul = mul_op_e'(md); d.div = div_op_e'(md);
        d.eng = eng; d.wb = wb; d.pcs = pcs; d.br = br;
        d.mem_op = mem_op; d.dir = dir; d.size = size; d.ecall = ecall; d.illegal = illegal;
        return d;
    endfunction

    function automatic dec_t dut_bundle();
        dec_t d;
        d.pc = out_pc; d.imm = out_imm; d.rd = out_rd; d.rs1 = out_rs1; d.rs2 = out_rs2;
        d.imm_type = out_imm_type; d.src = out_exec_src; d.alu = out_alu_op;
        d.mul = out_mul_op; d.div = out_div_op; d.eng = out_exec_engine;
        d.wb = out_wb_src; d.pcs = out_pc_src; d.br = out_br_type;
        d.mem_op = out_mem_op; d.dir = out_mem_dir; d.size = out_mem_size;
        d.ecall = out_ecall; d.illegal = out_illegal;
        return d;
    endfunction

    // Scoreboard: every handshake on the output side is compared with the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_pc=%0h required=none", out_pc);
            end else begin
                mon_exp = sb.pop_front();
                check_dec("head_entry", dut_bundle(), mon_exp);
            end
        end
    end

    // Offer one vector at the current negedge; wait a bounded time for acceptance.
    task automatic push_vec(input int idx, input logic [31:0] pc);
        int   waited;
        dec_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_instr = vecs[idx].instr;
        in_pc    = pc;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=in_ready_low required=accept idx=%0d", idx);
            in_valid = 1'b0;
        end else begin
            e    = vecs[idx].exp;
            e.pc = pc;
            sb.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited;
        waited    = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_scoreboard", 64'(sb.size()), 64'd0);
        check("drain_count", 64'(count), 64'd0);
    endtask

    initial begin
        dec_t        e;
        int          k;
        logic [31:0] pc;

        vecs[0].instr  = 32'h00500093;  // ADDI x1,x0,5
        vecs[0].exp    = mk(5'd1, 5'd0, 5'd5, 32'd5, IMM_I, SRC_RI, ALU_ADD, 2'd0, EXEC_ALU, WB_EXEC, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b0, 1'b0);
        vecs[1].instr  = 32'h40208133;  // SUB x2,x1,x2
        vecs[1].exp    = mk(5'd2, 5'd1, 5'd2, 32'h402, IMM_I, SRC_RR, ALU_SUB, 2'd0, EXEC_ALU, WB_EXEC, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b0, 1'b0);
        vecs[2].instr  = 32'h022081B3;  // MUL x3,x1,x2
        vecs[2].exp    = mk(5'd3, 5'd1, 5'd2, 32'h22, IMM_I, SRC_RR, ALU_ADD, 2'd0, EXEC_MUL, WB_EXEC, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b0, 1'b0);
        vecs[3].instr  = 32'hFE000EE3;  // BEQ x0,x0,-4
        vecs[3].exp    = mk(5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, IMM_B, SRC_RR, ALU_SUB, 2'd0, EXEC_ALU, WB_NONE, PC_BRANCH, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b0, 1'b0);
        vecs[4].instr  = 32'h00000073;  // ECALL
        vecs[4].exp    = mk(5'd0, 5'd0, 5'd0, 32'd0, IMM_I, SRC_RR, ALU_ADD, 2'd0, EXEC_ALU, WB_NONE, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b1, 1'b0);
        vecs[5].instr  = 32'h00000000;  // all-zero encoding
        vecs[5].exp    = mk(5'd0, 5'd0, 5'd0, 32'd0, IMM_I, SRC_RR, ALU_ADD, 2'd0, EXEC_ALU, WB_NONE, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b0, ILL_ZERO);
        vecs[6].instr  = 32'hFF812283;  // LW x5,-8(x2)
        vecs[6].exp    = mk(5'd5, 5'd2, 5'd24, 32'hFFFFFFF8, IMM_I, SRC_RI, ALU_ADD, 2'd2, EXEC_ALU, WB_MEM, PC_NORMAL, BRANCH_Z, 1'b1, MEM_READ, MEM_W, 1'b0, 1'b0);
        vecs[7].instr  = 32'h0063A623;  // SW x6,12(x7)
        vecs[7].exp    = mk(5'd12, 5'd7, 5'd6, 32'd12, IMM_S, SRC_RI, ALU_ADD, 2'd2, EXEC_ALU, WB_NONE, PC_NORMAL, BRANCH_Z, 1'b1, MEM_WRITE, MEM_W, 1'b0, 1'b0);
        vecs[8].instr  = 32'h008000EF;  // JAL x1,+8
        vecs[8].exp    = mk(5'd1, 5'd0, 5'd8, 32'd8, IMM_J, SRC_PI, ALU_ADD, 2'd0, EXEC_ALU, WB_FETCH, PC_JUMP, BRANCH_Z, 1'b0, MEM_READ, MEM_B, 1'b0, 1'b0);
        vecs[9].instr  = 32'h12345537;  // LUI x10,0x12345
        vecs[9].exp    = mk(5'd10, 5'd8, 5'd3, 32'h12345000, IMM_U, SRC_ZI, ALU_ADD, 2'd1, EXEC_ALU, WB_EXEC, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_HU, 1'b0, 1'b0);
        vecs[10].instr = 32'h40325213;  // SRAI x4,x4,3
        vecs[10].exp   = mk(5'd4, 5'd4, 5'd3, 32'h403, IMM_I, SRC_RI, ALU_SRA, 2'd1, EXEC_ALU, WB_EXEC, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_HU, 1'b0, 1'b0);
        vecs[11].instr = 32'h0020E863;  // BLTU x1,x2,+16
        vecs[11].exp   = mk(5'd16, 5'd1, 5'd2, 32'd16, IMM_B, SRC_RR, ALU_SLTU, 2'd2, EXEC_ALU, WB_NONE, PC_BRANCH, BRANCH_NZ, 1'b0, MEM_READ, mem_size_e'(3'd6), 1'b0, 1'b0);
        vecs[12].instr = 32'h027352B3;  // DIVU x5,x6,x7
        vecs[12].exp   = mk(5'd5, 5'd6, 5'd7, 32'h27, IMM_I, SRC_RR, ALU_SRL, 2'd1, EXEC_DIV, WB_EXEC, PC_NORMAL, BRANCH_Z, 1'b0, MEM_READ, MEM_HU, 1'b0, 1'b0);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'd0; in_instr = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_count", 64'(count), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check_dec("reset_fields", dut_bundle(), '0);

        // First instruction: visible one cycle after acceptance.
        out_ready = 1'b1;
        push_vec(0, 32'h00001000);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("latency_count", 64'(count), 64'd1);

        // Whole table back to back.
        pc = 32'h00002000;
        for (int i = 0; i < NV; i++) begin
            push_vec(i, pc);
            pc = pc + 32'd4;
        end
        drain();

        // Full queue: no pass-through on a same-cycle pop, then refill.
        out_ready = 1'b0;
        push_vec(1, 32'h00003000);
        push_vec(2, 32'h00003004);
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b1;
        in_instr  = vecs[3].instr;
        in_pc     = 32'h00003008;
        out_ready = 1'b1;
        check("full_pop_push_refused", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("after_pop_count", 64'(count), 64'd1);
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        e = vecs[3].exp; e.pc = 32'h00003008; sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("refill_count", 64'(count), 64'd2);
        drain();

        // Random traffic across many pointer wraps.
        k  = 0;
        pc = 32'h00004000;
        for (int c = 0; c < 80; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_instr  = vecs[k].instr;
            in_pc     = pc;
            if (in_valid && in_ready) begin
                e = vecs[k].exp; e.pc = pc; sb.push_back(e);
                k  = (k + 1) % NV;
                pc = pc + 32'd4;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Flush on a full queue with an offered instruction.
        out_ready = 1'b0;
        push_vec(6, 32'h00005000);
        push_vec(7, 32'h00005004);
        flush = 1'b1; in_valid = 1'b1; in_instr = vecs[8].instr; in_pc = 32'h00005008;
        sb.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_full_count", 64'(count), 64'd0);
        check("flush_full_out_valid", 64'(out_valid), 64'd0);

        // Flush overriding an accepted push and a pop in the same cycle.
        push_vec(9, 32'h00006000);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = vecs[10].instr; in_pc = 32'h00006004;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_push_count", 64'(count), 64'd0);
        check("flush_push_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("flush_stays_empty", 64'(count), 64'd0);
        push_vec(11, 32'h00006100);
        drain();

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        push_vec(12, 32'h00007000);
        push_vec(0, 32'h00007004);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("async_reset_count", 64'(count), 64'd0);
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_vec(2, 32'h00008000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_decode_queue.md
Name: core_decode_queue

Overview:
- Buffered, pipelined RV32IM decode stage between fetch and execute.
- Accepts {pc, instr} through a valid/ready handshake and decodes at enqueue.
- Stores the decoded control bundle plus the generated immediate in a DEPTH-entry circular queue.
- Presents the head entry to execute through a second valid/ready handshake. Supports pipeline flush.

Parameters:
- DEPTH, 2, queue entries; power of two, ≥2.
- XLEN, 32, width of pc and immediate.
- M_EXT, 1, 1 = decode MUL/DIV ops; 0 = funct7 0000001 on OP is treated as non-M (ALU, flagged illegal when the feature is enabled).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop all queued entries
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  queue can accept
- in_pc  in  XLEN  instruction address
- in_instr  in  32  raw instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_pc  out  XLEN  head pc
- out_imm  out  XLEN  sign-extended immediate per imm_type
- out_rd / out_rs1 / out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20])
- out_imm_type  out  core_pkg::imm_type_e
- out_exec_src  out  core_pkg::exec_src_e
- out_alu_op  out  core_pkg::alu_op_e
- out_mul_op  out  core_pkg::mul_op_e
- out_div_op  out  core_pkg::div_op_e
- out_exec_engine  out  core_pkg::exec_engine_e
- out_wb_src  out  core_pkg::wb_src_e
- out_pc_src  out  core_pkg::pc_src_e
- out_br_type  out  core_pkg::br_type_e
- out_mem_op  out  1  load/store
- out_mem_dir  out  core_pkg::mem_dir_e
- out_mem_size  out  core_pkg::mem_size_e
- out_ecall  out  1  ECALL
- out_illegal  out  1  illegal encoding
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: read/write pointers 0, count 0, out_valid 0, in_ready 1. All entry storage is cleared to 0, so every out_* field reads 0 after reset.
- Decode table, applied to in_instr at enqueue:
  - OP: IMM_I/SRC_RR/WB_EXEC/PC_NORMAL.
  - OPIMM: IMM_I/SRC_RI/WB_EXEC/PC_NORMAL.
  - LUI: IMM_U/SRC_ZI/WB_EXEC/PC_NORMAL.
  - AUIPC: IMM_U/SRC_PI/WB_EXEC/PC_NORMAL.
  - JAL: IMM_J/SRC_PI/WB_FETCH/PC_JUMP.
  - JALR: IMM_I/SRC_RI/WB_FETCH/PC_JUMP.
  - BRANCH: IMM_B/SRC_RR/WB_NONE/PC_BRANCH.
  - LOAD: IMM_I/SRC_RI/WB_MEM/PC_NORMAL, mem_op=1, MEM_READ.
  - STORE: IMM_S/SRC_RI/WB_NONE/PC_NORMAL, mem_op=1, MEM_WRITE.
  - Default: IMM_I/SRC_RR/WB_NONE/PC_NORMAL.
  - mem_dir is MEM_READ everywhere except STORE. mem_size = funct3.
- ALU op:
  - OP: {instr[30], funct3}.
  - OPIMM: {instr[30], funct3} for shifts (funct3[1:0]=01), else {0, funct3}.
  - BRANCH: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU.
  - Otherwise ADD.
- Branch type: BEQ/BGE/BGEU→BRANCH_Z; BNE/BLT/BLTU→BRANCH_NZ.
- Engine:
  - OP with instr[25]=1 and M_EXT=1: EXEC_MUL if funct3[2]=0, EXEC_DIV if 1.
  - Otherwise EXEC_ALU.
  - mul_op = div_op = funct3[1:0].
- ecall = opcode SYSTEM and instr[31:7]==0.
- Immediates (all sign-extended from instr[31] to XLEN):
  - I = instr[31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],0}.
- Push/pop:
  - Push when in_valid & in_ready. Decoded entry is written at wptr; wptr increments modulo DEPTH.
  - Pop when out_valid & out_ready; rptr increments modulo DEPTH.
  - Latency: an instruction accepted in cycle N is visible on out_* with out_valid=1 in cycle N+1. There is no combinational bypass.
- Status: in_ready = (count != DEPTH), with no pass-through when full, even if a pop occurs the same cycle. out_valid = (count != 0).
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Head stability: out_* is stable while out_valid=1 and out_ready=0.
- flush:
  - Synchronous. Next cycle pointers=0, count=0, out_valid=0.
  - Overrides a same-cycle push and pop; the pushed instruction is discarded.
  - in_ready remains 1 during flush.
- Reset mid-operation: queue empties immediately (asynchronous); no entry survives.

Optional Feature:
- Macro: CORE_DECODE_QUEUE_ILLEGAL_EN.
- When defined, out_illegal=1 for any of:
  - opcode not in {OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, MISC_MEM}.
  - instr[1:0] != 2'b11.
  - BRANCH funct3 ∈ {010, 011}.
  - LOAD funct3 ∈ {011, 110, 111}.
  - STORE funct3 ≥ 011.
  - JALR funct3 ≠ 0.
  - OP funct7 not in {0000000, 0100000 (only for funct3 000/101), 0000001 (only if M_EXT)}.
  - OPIMM shift with illegal funct7.
- Illegal entries are still queued in order with the default control bundle.
- When undefined, out_illegal is tied to 0 and no illegal-check logic is generated.

Test Plan:
- Push 0x00500093 (ADDI x1,x0,5), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=5, ALU_ADD, SRC_RI, WB_EXEC, EXEC_ALU.
- Push 0x40208133 (SUB x2,x1,x2), then 0x022081B3 (MUL x3,x1,x2) with M_EXT=1 → entries in order: ALU_SUB/EXEC_ALU, then EXEC_MUL with mul_op=0.
- Push 0xFE000EE3 (BEQ x0,x0,-4) → IMM_B, imm=0xFFFFFFFC, ALU_SUB, BRANCH_Z, PC_BRANCH, WB_NONE.
- out_ready=0, push DEPTH=2 instructions → count=2, in_ready=0; a third in_valid is not accepted. Same cycle pop+push offered → push refused. Next cycle count=1 then refill. Order preserved across pointer wrap.
- Queue holding 2 entries, assert flush with in_valid=1 → next cycle count=0, out_valid=0, the pushed instruction is never output.
- With CORE_DECODE_QUEUE_ILLEGAL_EN: push 0x00000000 → out_illegal=1. Push 0x00000073 → out_ecall=1, out_illegal=0.
